// File: rtl/instr_fetch_decode_pkg.sv
// Shared definitions for the fetch/decode stage and the instruction field decoder:
// opcode constants, FSM state encoding, field bit positions and the decoded-field payload.
package instr_fetch_decode_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned OPCODE_W  = 6;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned SHAMT_W   = 5;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned IMM_W     = 16;

  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_LSB    = 0;

  localparam logic [OPCODE_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ifd_state_e;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [SHAMT_W-1:0]  shamt;
    logic [FUNCT_W-1:0]  funct;
    logic [IMM_W-1:0]    imm;
    logic [INSTR_W-1:0]  imm_sext;
    logic                is_load;
    logic                is_store;
  } ifd_fields_t;

endpackage

// File: rtl/instr_field_decoder.sv
// Purely combinational split of a 32-bit instruction word into its fields,
// sign-extended immediate and load/store flags; shared with the execute stage.
module instr_field_decoder
  import instr_fetch_decode_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output ifd_fields_t        fields_c
);

  logic [OPCODE_W-1:0] opcode_c;

  assign opcode_c = instr[OPCODE_LSB +: OPCODE_W];

  always_comb begin
    fields_c          = '0;
    fields_c.opcode   = opcode_c;
    fields_c.rs       = instr[RS_LSB +: REG_W];
    fields_c.rt       = instr[RT_LSB +: REG_W];
    fields_c.rd       = instr[RD_LSB +: REG_W];
    fields_c.shamt    = instr[SHAMT_LSB +: SHAMT_W];
    fields_c.funct    = instr[FUNCT_LSB +: FUNCT_W];
    fields_c.imm      = instr[IMM_LSB +: IMM_W];
    fields_c.imm_sext = {{(INSTR_W-IMM_W){instr[IMM_LSB+IMM_W-1]}}, instr[IMM_LSB +: IMM_W]};
    fields_c.is_load  = (opcode_c == OP_LW);
    fields_c.is_store = (opcode_c == OP_SW);
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode stage: word-addressed imem, pc, registered decoded output with
// valid/ready back-pressure. Optional macro IFD_REDIRECT_EN adds a pc redirect/flush port.
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int unsigned          IMEM_DEPTH  = 32,
  parameter logic [OPCODE_W-1:0]  HALT_OPCODE = OP_HALT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [31:0]                   start_pc,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
`ifdef IFD_REDIRECT_EN
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_pc,
  output logic [5:0]                    out_opcode,
  output logic [4:0]                    out_rs,
  output logic [4:0]                    out_rt,
  output logic [4:0]                    out_rd,
  output logic [4:0]                    out_shamt,
  output logic [5:0]                    out_funct,
  output logic [15:0]                   out_imm,
  output logic [31:0]                   out_imm_sext,
  output logic                          out_is_load,
  output logic                          out_is_store,
  output logic                          busy,
  output logic                          done,
  output logic                          pc_overrun,
  output logic [15:0]                   fetch_count
);

  localparam int unsigned AW       = $clog2(IMEM_DEPTH);
  localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_DEPTH);

  logic [INSTR_W-1:0] imem [IMEM_DEPTH];

  ifd_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  ifd_fields_t fields_q;
  ifd_fields_t fetched_c;

  logic slot_c, overrun_c, halt_c, redirect_c;
  logic load_c, clear_c, start_c, set_overrun_c;

  logic unused_pc_low;
`ifdef IFD_REDIRECT_EN
  assign redirect_c    = redirect_valid && (state_q != ST_IDLE);
  assign unused_pc_low = ^{start_pc[1:0], redirect_pc[1:0]};
`else
  assign redirect_c    = 1'b0;
  assign unused_pc_low = ^start_pc[1:0];
`endif

  // Memory is only writable while idle and is deliberately not reset.
  always_ff @(posedge clk) begin
    if (imem_we && (state_q == ST_IDLE)) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  instr_field_decoder u_decoder (
    .instr    (imem[pc_q[AW+1:2]]),
    .fields_c (fetched_c)
  );

  assign slot_c    = !out_valid || out_ready;
  assign overrun_c = (pc_q >= PC_LIMIT);
  assign halt_c    = (fetched_c.opcode == HALT_OPCODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (slot_c && (overrun_c || halt_c)) state_d = ST_DRAIN;
      ST_DRAIN: if (slot_c) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (redirect_c) state_d = ST_RUN;
  end

  // Overrun is tested before halt: past the end, the fetched word is meaningless.
  always_comb begin
    load_c        = 1'b0;
    clear_c       = 1'b0;
    start_c       = 1'b0;
    set_overrun_c = 1'b0;
    pc_d          = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_c = 1'b1;
          pc_d    = {start_pc[31:2], 2'b00};
        end
      end
      ST_RUN: begin
        if (slot_c) begin
          if (overrun_c) begin
            set_overrun_c = 1'b1;
            clear_c       = 1'b1;
          end else if (halt_c) begin
            clear_c = 1'b1;
          end else begin
            load_c = 1'b1;
            pc_d   = pc_q + 32'd4;
          end
        end
      end
      ST_DRAIN: clear_c = slot_c;
      default: ;
    endcase
`ifdef IFD_REDIRECT_EN
    if (redirect_c) begin
      load_c        = 1'b0;
      clear_c       = 1'b1;
      set_overrun_c = 1'b0;
      pc_d          = {redirect_pc[31:2], 2'b00};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= '0;
      out_valid   <= 1'b0;
      out_pc      <= '0;
      fields_q    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pc_overrun  <= 1'b0;
      fetch_count <= '0;
    end else begin
      pc_q <= pc_d;
      busy <= (state_d != ST_IDLE);
      done <= (state_q == ST_DRAIN) && (state_d == ST_IDLE);
      if (load_c) begin
        fields_q  <= fetched_c;
        out_pc    <= pc_q;
        out_valid <= 1'b1;
      end else if (clear_c) begin
        out_valid <= 1'b0;
      end
      if (start_c) begin
        fetch_count <= '0;
      end else if (load_c && (fetch_count != 16'hFFFF)) begin
        fetch_count <= fetch_count + 16'd1;
      end
      if (start_c) begin
        pc_overrun <= 1'b0;
      end else if (set_overrun_c) begin
        pc_overrun <= 1'b1;
      end
    end
  end

  assign out_opcode   = fields_q.opcode;
  assign out_rs       = fields_q.rs;
  assign out_rt       = fields_q.rt;
  assign out_rd       = fields_q.rd;
  assign out_shamt    = fields_q.shamt;
  assign out_funct    = fields_q.funct;
  assign out_imm      = fields_q.imm;
  assign out_imm_sext = fields_q.imm_sext;
  assign out_is_load  = fields_q.is_load;
  assign out_is_store = fields_q.is_store;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: directed programs plus randomized memories,
// start addresses and back-pressure, checked against a program-walk reference model.
module tb_instr_fetch_decode;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   start_pc = '0;
  logic          imem_we = 1'b0;
  logic [AW-1:0] imem_waddr = '0;
  logic [31:0]   imem_wdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_pc;
  logic [5:0]    out_opcode;
  logic [4:0]    out_rs, out_rt, out_rd, out_shamt;
  logic [5:0]    out_funct;
  logic [15:0]   out_imm;
  logic [31:0]   out_imm_sext;
  logic          out_is_load, out_is_store;
  logic          busy, done, pc_overrun;
  logic [15:0]   fetch_count;

  logic [31:0] mem_model [DEPTH];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_fetch_decode #(.IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
`ifdef IFD_REDIRECT_EN
    .redirect_valid(1'b0), .redirect_pc(32'h0),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_imm(out_imm),
    .out_imm_sext(out_imm_sext), .out_is_load(out_is_load), .out_is_store(out_is_store),
    .busy(busy), .done(done), .pc_overrun(pc_overrun), .fetch_count(fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic write_word(input logic [AW-1:0] addr, input logic [31:0] data);
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = data;
    @(posedge clk); #1;
    imem_we    = 1'b0;
    mem_model[addr] = data;
  endtask

  function automatic logic [31:0] rand_word(input int halt_pct);
    logic [31:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(99);
    if (r < halt_pct)  w[31:26] = 6'b111111;
    else if (r < 45)   w[31:26] = 6'b100011;
    else if (r < 70)   w[31:26] = 6'b101011;
    else if (w[31:26] == 6'b111111) w[31:26] = 6'b000000;
    return w;
  endfunction

  task automatic fill_random(input int halt_pct);
    for (int i = 0; i < DEPTH; i++) write_word(AW'(i), rand_word(halt_pct));
  endtask

  // mode 0: random ready at ready_pct; mode 1: ready low for the first 4 sample points.
  task automatic run_prog(input string name, input logic [31:0] spc, input int mode,
                          input int ready_pct, input bit noise, input bit cw_en,
                          input logic [AW-1:0] cw_addr, input logic [31:0] cw_data);
    logic [31:0] exp_pc[$];
    logic [31:0] exp_w[$];
    logic [31:0] p, w, imm, sext;
    bit exp_over, rdy, seen;
    int idx, done_cyc, n;

    if (cw_en) mem_model[cw_addr] = cw_data;
    p = spc & 32'hFFFF_FFFC;
    exp_over = 1'b0;
    while (1) begin
      if (p >= 4 * DEPTH) begin exp_over = 1'b1; break; end
      w = mem_model[p[6:2]];
      if ((w >> 26) == 32'd63) break;
      exp_pc.push_back(p);
      exp_w.push_back(w);
      p = p + 4;
    end
    n = exp_pc.size();

    start_pc   = spc;
    start      = 1'b1;
    imem_we    = cw_en;
    imem_waddr = cw_addr;
    imem_wdata = cw_data;
    out_ready  = 1'b0;
    @(posedge clk); #1;
    start   = 1'b0;
    imem_we = 1'b0;
    check({name, ":busy_after_start"}, 32'(busy), 32'd1);

    idx = 0; seen = 1'b0; done_cyc = -1;
    for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
      rdy = (mode == 1) ? (cyc >= 4) : ($urandom_range(99) < ready_pct);
      out_ready = rdy;
      imem_we   = 1'b0;
      if (noise && busy) begin
        imem_we    = 1'b1;
        imem_waddr = AW'($urandom_range(11, 1));
        imem_wdata = $urandom;
      end
      if (mode == 1 && cyc >= 1 && cyc <= 3 && n > 0) begin
        check({name, ":stall_valid"}, 32'(out_valid), 32'd1);
        check({name, ":stall_pc"}, out_pc, exp_pc[0]);
        check({name, ":stall_count"}, 32'(fetch_count), 32'd1);
      end
      if (out_valid && rdy) begin
        if (idx < n) begin
          w    = exp_w[idx];
          imm  = w & 32'h0000_FFFF;
          sext = (imm >= 32'd32768) ? imm + 32'hFFFF_0000 : imm;
          check({name, ":pc"}, out_pc, exp_pc[idx]);
          check({name, ":opcode"}, 32'(out_opcode), w >> 26);
          check({name, ":rs"}, 32'(out_rs), (w >> 21) % 32);
          check({name, ":rt"}, 32'(out_rt), (w >> 16) % 32);
          check({name, ":rd"}, 32'(out_rd), (w >> 11) % 32);
          check({name, ":shamt"}, 32'(out_shamt), (w >> 6) % 32);
          check({name, ":funct"}, 32'(out_funct), w % 64);
          check({name, ":imm"}, 32'(out_imm), imm);
          check({name, ":imm_sext"}, out_imm_sext, sext);
          check({name, ":is_load"}, 32'(out_is_load), 32'((w >> 26) == 32'd35));
          check({name, ":is_store"}, 32'(out_is_store), 32'((w >> 26) == 32'd43));
          if (mode == 1) check({name, ":accept_cycle"}, 32'(cyc), 32'(idx + 4));
          else if (ready_pct == 100) check({name, ":accept_cycle"}, 32'(cyc), 32'(idx + 1));
        end
        idx++;
      end
      if (done) begin
        seen = 1'b1;
        done_cyc = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    imem_we   = 1'b0;
    out_ready = 1'b0;

    check({name, ":done_seen"}, 32'(seen), 32'd1);
    check({name, ":emitted"}, 32'(idx), 32'(n));
    check({name, ":fetch_count"}, 32'(fetch_count), 32'(n));
    check({name, ":pc_overrun"}, 32'(pc_overrun), 32'(exp_over));
    check({name, ":busy_idle"}, 32'(busy), 32'd0);
    check({name, ":valid_idle"}, 32'(out_valid), 32'd0);
    if (mode == 1 && n > 0) check({name, ":done_cycle"}, 32'(done_cyc), 32'(n + 5));
    else if (mode == 0 && ready_pct == 100) check({name, ":done_cycle"}, 32'(done_cyc), 32'(n + 2));
    @(posedge clk); #1;
    check({name, ":done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int done_seen_after_reset;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset:out_valid", 32'(out_valid), 32'd0);
    check("reset:out_pc", out_pc, 32'd0);
    check("reset:opcode", 32'(out_opcode), 32'd0);
    check("reset:imm_sext", out_imm_sext, 32'd0);
    check("reset:done", 32'(done), 32'd0);
    check("reset:pc_overrun", 32'(pc_overrun), 32'd0);
    check("reset:fetch_count", 32'(fetch_count), 32'd0);
    check("reset:busy", 32'(busy), 32'd0);

    fill_random(0);
    write_word(5'd0, 32'h8C220004);
    write_word(5'd1, 32'hAC430008);
    write_word(5'd2, 32'hFC000000);
    run_prog("lw_sw", 32'h0, 0, 100, 1'b0, 1'b0, '0, '0);
    run_prog("stall", 32'h0, 1, 0, 1'b0, 1'b0, '0, '0);

    write_word(5'd3, 32'h8C228000);
    write_word(5'd4, 32'hFC000000);
    run_prog("neg_imm", 32'hC, 0, 100, 1'b0, 1'b0, '0, '0);

    write_word(5'd30, 32'h8C220004);
    write_word(5'd31, 32'hAC430008);
    run_prog("overrun", 32'd120, 0, 100, 1'b0, 1'b0, '0, '0);
    run_prog("far_start", 32'd200, 0, 100, 1'b0, 1'b0, '0, '0);

    for (int i = 1; i <= 10; i++) write_word(AW'(i), rand_word(0));
    write_word(5'd11, 32'hFC000000);
    run_prog("busy_writes", 32'h6, 0, 50, 1'b1, 1'b0, '0, '0);
    run_prog("busy_writes_rerun", 32'h4, 0, 100, 1'b0, 1'b0, '0, '0);

    write_word(5'd17, 32'hFC000000);
    run_prog("start_with_write", 32'h40, 0, 100, 1'b0, 1'b1, 5'd16, 32'h8C2300FF);

    // Abort mid-run: reset clears outputs without a clock edge and no done follows.
    write_word(5'd20, 32'h8C220004);
    write_word(5'd21, 32'hAC430008);
    start_pc = 32'd80;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort:valid_before", 32'(out_valid), 32'd1);
    check("abort:pc_before", out_pc, 32'd80);
    #2 rst_n = 1'b0;
    #1;
    check("abort:valid", 32'(out_valid), 32'd0);
    check("abort:busy", 32'(busy), 32'd0);
    check("abort:fetch_count", 32'(fetch_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    done_seen_after_reset = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_seen_after_reset++;
      @(posedge clk); #1;
    end
    check("abort:no_done", 32'(done_seen_after_reset), 32'd0);

    for (int r = 0; r < 20; r++) begin
      int pct;
      fill_random(8);
      pct = (r % 3 == 0) ? 100 : ((r % 3 == 1) ? 70 : 30);
      run_prog($sformatf("rand%0d", r), 32'($urandom_range(135)), 0, pct,
               1'b0, 1'b0, '0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Upstream stage of the I-type load/store execute block.
- Holds a word-addressed instruction memory and a program counter.
- Fetches one 32-bit instruction per cycle and splits it into opcode/rs/rt/rd/shamt/funct/imm fields.
- Presents the fields in a registered output stage with a valid/ready handshake, so the execute stage can stall fetch.

Parameters:
- IMEM_DEPTH, 32, number of 32-bit instruction words. Power of two, at least 2.
- HALT_OPCODE, 6'b111111, opcode that terminates a run. The halt instruction itself is not emitted.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begins a run; honoured only in IDLE
- start_pc  in  32  byte address of the first instruction; bits [1:0] ignored
- imem_we  in  1  instruction memory write enable; honoured only in IDLE
- imem_waddr  in  $clog2(IMEM_DEPTH)  word index to write
- imem_wdata  in  32  instruction word to write
- out_valid  out  1  output register holds a decoded instruction
- out_ready  in  1  consumer accepts the instruction when out_valid && out_ready
- out_pc  out  32  byte address of the emitted instruction
- out_opcode  out  6  instr[31:26]
- out_rs  out  5  instr[25:21]
- out_rt  out  5  instr[20:16]
- out_rd  out  5  instr[15:11]
- out_shamt  out  5  instr[10:6]
- out_funct  out  6  instr[5:0]
- out_imm  out  16  instr[15:0]
- out_imm_sext  out  32  {{16{instr[15]}}, instr[15:0]}
- out_is_load  out  1  opcode == 6'b100011
- out_is_store  out  1  opcode == 6'b101011
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on DRAIN -> IDLE
- pc_overrun  out  1  sticky; set when a run ends by running past the memory; cleared on start
- fetch_count  out  16  instructions emitted in the current run; saturates at 16'hFFFF; cleared on start

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, pc = 0.
  - out_valid = 0 and all out_* fields = 0.
  - done = 0, pc_overrun = 0, fetch_count = 0.
  - Instruction memory contents are not reset.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - imem_we writes imem[imem_waddr] <= imem_wdata on the clock edge.
  - start: pc <= {start_pc[31:2], 2'b00}; fetch_count <= 0; pc_overrun <= 0; go to RUN.
  - start and imem_we in the same cycle: both take effect. The write lands before the first fetch, one cycle later.
- RUN:
  - A load slot exists when !out_valid || out_ready.
  - Word index = pc[AW+1:2].
  - pc >= 4*IMEM_DEPTH with a slot available: set pc_overrun; go to DRAIN; emit nothing.
  - Fetched word has opcode == HALT_OPCODE with a slot available: go to DRAIN; emit nothing; pc unchanged.
  - Otherwise, with a slot available:
    - Load the output register with the decoded fields; out_pc <= pc; out_valid <= 1.
    - pc <= pc + 4.
    - fetch_count increments, saturating.
  - No slot available (out_valid && !out_ready): output register and pc hold; fields stay stable.
  - Accept without a new load (the DRAIN case): out_valid <= 0.
  - Latency: an instruction at pc appears on the outputs the cycle after pc is presented.
  - Throughput: 1 instruction/cycle while out_ready is high.
- DRAIN:
  - No fetch.
  - Go to IDLE and pulse done when !out_valid, or when out_valid && out_ready (out_valid <= 0 in the same edge).
  - done is asserted in the first IDLE cycle only.
- Writes and start outside IDLE are ignored.
- Reset asserted mid-run aborts immediately; the partial run is not reported.
- The pc overrun check has priority over the halt check.

Optional Feature:
- Macro: IFD_REDIRECT_EN.
- Defined: adds inputs redirect_valid (1) and redirect_pc (32).
  - In RUN or DRAIN, redirect_valid flushes the output register: out_valid <= 0.
  - pc <= {redirect_pc[31:2], 2'b00}; state <= RUN.
  - A redirect overrides the halt, overrun and normal-fetch actions in the same cycle.
  - In IDLE the redirect is ignored.
- Not defined: ports absent; pc advances only sequentially.

Decomposition:
- Shared package holds:
  - opcode constants OP_LW=6'b100011, OP_SW=6'b101011, OP_HALT=6'b111111;
  - the state encoding;
  - the field bit-position constants.
- One natural sub-module: instr_field_decoder, purely combinational. Maps a 32-bit word to the field, sign-extended immediate and is_load/is_store outputs. It is reused by the execute stage.

Test Plan:
- Load imem[0..2] = 32'h8C220004 (lw), 32'hAC430008 (sw), 32'hFC000000 (halt); start with start_pc=0 and out_ready=1 -> two outputs on consecutive cycles:
  - first: out_pc=0, rs=1, rt=2, imm_sext=32'h4, is_load=1;
  - second: out_pc=4, rs=2, rt=3, is_store=1;
  - then done pulses, fetch_count=2.
- Same program with out_ready=0 for 3 cycles after the first out_valid -> fields stable at out_pc=0; no pc advance; the second instruction appears the cycle after out_ready rises.
- imm=16'h8000 word (32'h8C228000) -> out_imm_sext=32'hFFFF8000.
- IMEM_DEPTH=4, no halt, start_pc=8 -> emits pc 8 and 12, then pc_overrun=1 and done pulses.
- Assert rst_n low during RUN with out_valid=1 -> out_valid=0, busy=0 immediately with no clock edge; no done pulse afterward.
- start_pc=32'h6, plus imem_we pulses while busy -> first out_pc=4; imem contents unchanged by the busy-time writes.
